axilite_bk_regbank: RTL

- Register bank that sits directly downstream of the AXI-Lite slave's backend interface. It consumes bk_wstart/bk_waddr/bk_wdata/bk_wstrb and bk_rstart/bk_raddr, and returns bk_rdata/bk_rdone after a fixed read latency.
- Holds NUM_REGS 32-bit control/status registers that are also readable and writable by user hardware.
- Flags decode errors and protocol violations with sticky bits.

---
 rtl/axilite_bk_regbank.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/axilite_bk_regbank.sv
// Backend register bank for an AXI-Lite slave: byte-strobed writes, fixed-latency reads, sticky error flags.
// Optional macro AXILITE_BK_RO_MASK_EN adds RO_MASK to make selected registers backend read-only.
module axilite_bk_regbank #(
    parameter int          NUM_REGS   = 16,
    parameter logic [14:0] BASE_ADDR  = 15'h0000,
    parameter int          RD_LATENCY = 2
`ifdef AXILITE_BK_RO_MASK_EN
    ,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
`endif
) (
    input  logic                     axi_aclk,
    input  logic                     axi_areset,
    input  logic                     bk_wstart,
    input  logic [14:0]              bk_waddr,
    input  logic [31:0]              bk_wdata,
    input  logic [3:0]               bk_wstrb,
    input  logic                     bk_rstart,
    input  logic [14:0]              bk_raddr,
    output logic [31:0]              bk_rdata,
    output logic                     bk_rdone,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse,
    input  logic [NUM_REGS-1:0]      hw_we,
    input  logic [NUM_REGS*32-1:0]   hw_wdata,
    output logic                     err_addr,
    output logic                     err_busy,
    input  logic                     err_clr
);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DONE
    } rd_state_e;

    localparam logic [12:0] NUM_REGS_W  = 13'(NUM_REGS);
    localparam logic [2:0]  CNT_INIT    = 3'(RD_LATENCY - 1);
    localparam rd_state_e   FIRST_STATE = (RD_LATENCY == 1) ? RD_DONE : RD_WAIT;

    logic [NUM_REGS*32-1:0] reg_d;
    logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;
    rd_state_e              rd_state_q, rd_state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [31:0]            snap_q, snap_d;
    logic                   err_addr_q, err_addr_d;
    logic                   err_busy_q, err_busy_d;

    logic [14:0] w_off, r_off;
    logic [12:0] w_idx, r_idx;
    logic        w_in_range, r_in_range;
    logic        w_ro, w_ok, w_err;
    logic        r_err, r_busy;
    logic [31:0] r_data;

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign w_off      = bk_waddr - BASE_ADDR;
    assign r_off      = bk_raddr - BASE_ADDR;
    assign w_idx      = w_off[14:2];
    assign r_idx      = r_off[14:2];
    assign w_in_range = (w_off[1:0] == 2'b00) && (w_idx < NUM_REGS_W);
    assign r_in_range = (r_off[1:0] == 2'b00) && (r_idx < NUM_REGS_W);

`ifdef AXILITE_BK_RO_MASK_EN
    always_comb begin
        w_ro = 1'b0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (w_idx == 13'(n)) w_ro = RO_MASK[n];
        end
    end
`else
    assign w_ro = 1'b0;
`endif

    assign w_ok  = bk_wstart && w_in_range && !w_ro;
    assign w_err = bk_wstart && !w_ok;

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        reg_d      = reg_q;
        wr_pulse_d = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (hw_we[n]) reg_d[32*n +: 32] = hw_wdata[32*n +: 32];
            // Backend strobed bytes override the hardware value on a collision.
            if (w_ok && (w_idx == 13'(n))) begin
                wr_pulse_d[n] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (bk_wstrb[b]) reg_d[32*n + 8*b +: 8] = bk_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        r_data = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (r_in_range && (r_idx == 13'(n))) r_data = reg_q[32*n +: 32];
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        r_err      = 1'b0;
        r_busy     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (bk_rstart) begin
                    snap_d     = r_data;
                    r_err      = !r_in_range;
                    cnt_d      = CNT_INIT;
                    rd_state_d = FIRST_STATE;
                end
            end
            RD_WAIT: begin
                r_busy = bk_rstart;
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) rd_state_d = RD_DONE;
            end
            RD_DONE: begin
                r_busy     = bk_rstart;
                rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr wins over the clear.
    always_comb begin
        err_addr_d = err_addr_q & ~err_clr;
        err_busy_d = err_busy_q & ~err_clr;
        if (w_err || r_err) err_addr_d = 1'b1;
        if (r_busy)         err_busy_d = 1'b1;
    end

    // NOTE: the register array is reset here on purpose; the bank must read back 0 after reset.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            reg_q      <= '0;
            wr_pulse_q <= '0;
            rd_state_q <= RD_IDLE;
            cnt_q      <= '0;
            snap_q     <= '0;
            err_addr_q <= 1'b0;
            err_busy_q <= 1'b0;
        end else begin
            reg_q      <= reg_d;
            wr_pulse_q <= wr_pulse_d;
            rd_state_q <= rd_state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            err_addr_q <= err_addr_d;
            err_busy_q <= err_busy_d;
        end
    end

    assign bk_rdone = (rd_state_q == RD_DONE);
    assign bk_rdata = bk_rdone ? snap_q : '0;
    assign wr_pulse = wr_pulse_q;
    assign err_addr = err_addr_q;
    assign err_busy = err_busy_q;

endmodule
